// File: rtl/commit_arbiter.sv
// Round-robin arbiter that moves one pending ALU result per cycle into a single
// registered writeback slot and pulses the clear of the ALU it accepted.
module commit_arbiter #(
   parameter int unsigned N_ALU      = 4,
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_ALU-1:0]            alu_valid,
   input  logic [N_ALU*XLEN-1:0]       alu_res,
   input  logic [N_ALU*REG_ADDR_W-1:0] alu_rd,
   input  logic [N_ALU-1:0]            alu_error,
   output logic [N_ALU-1:0]            alu_clear,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [REG_ADDR_W-1:0]       wb_rd,
   output logic [XLEN-1:0]             wb_data,
   output logic                        wb_error,
   output logic [$clog2(N_ALU)-1:0]    wb_src
);

   localparam int unsigned SrcW = $clog2(N_ALU);

   logic [SrcW-1:0]       rr_ptr_q;
   logic [SrcW-1:0]       grant;
   logic [SrcW:0]         idx;
   logic [N_ALU-1:0]      mask_q;
   logic [N_ALU-1:0]      eligible;
   logic                  found;
   logic                  slot_free;
   logic                  capture;
   logic                  discard;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_res;
   logic                  sel_err;

   assign slot_free = !wb_valid || wb_ready;
   // An ALU cleared last cycle may still show valid while it returns to idle.
   assign eligible  = alu_valid & ~mask_q;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_ALU; k++) begin
         idx = {1'b0, rr_ptr_q} + (SrcW+1)'(k);
         if (idx >= (SrcW+1)'(N_ALU)) begin
            idx = idx - (SrcW+1)'(N_ALU);
         end
         if (!found && eligible[idx[SrcW-1:0]]) begin
            found = 1'b1;
            grant = idx[SrcW-1:0];
         end
      end
   end

   always_comb begin
      sel_res = '0;
      sel_rd  = '0;
      sel_err = 1'b0;
      for (int i = 0; i < N_ALU; i++) begin
         if (grant == SrcW'(i)) begin
            sel_res = alu_res[i*XLEN +: XLEN];
            sel_rd  = alu_rd[i*REG_ADDR_W +: REG_ADDR_W];
            sel_err = alu_error[i];
         end
      end
   end

   assign capture = slot_free && found;
   // Writes to x0 without an error carry no architectural effect.
   assign discard = (sel_rd == '0) && !sel_err;

   always_comb begin
      alu_clear = '0;
      if (capture && !rst) begin
         alu_clear[grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         wb_error <= 1'b0;
         wb_src   <= '0;
         rr_ptr_q <= '0;
         mask_q   <= '0;
      end else begin
         mask_q <= alu_clear;
         if (capture) begin
            rr_ptr_q <= (grant == SrcW'(N_ALU - 1)) ? '0 : grant + 1'b1;
            if (discard) begin
               wb_valid <= 1'b0;
            end else begin
               wb_valid <= 1'b1;
               wb_rd    <= sel_rd;
               wb_data  <= sel_res;
               wb_error <= sel_err;
               wb_src   <= grant;
            end
         end else if (wb_valid && wb_ready) begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_commit_arbiter.sv
// Bench for commit_arbiter: directed scenarios plus randomized ALU traffic, all
// checked every cycle against a queue-free behavioural model of the slot.
module tb_commit_arbiter;

   localparam int N  = 4;
   localparam int XL = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  v;
   logic [N-1:0]  err;
   logic [XL-1:0] res [N];
   logic [RW-1:0] rd  [N];
   logic [N*XL-1:0] alu_res;
   logic [N*RW-1:0] alu_rd;
   logic          wb_ready;
   logic [N-1:0]  alu_clear;
   logic          wb_valid;
   logic [RW-1:0] wb_rd;
   logic [XL-1:0] wb_data;
   logic          wb_error;
   logic [1:0]    wb_src;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit          m_valid, n_valid;
   bit [RW-1:0] m_rd, n_rd;
   bit [XL-1:0] m_data, n_data;
   bit          m_err, n_err;
   int          m_src, n_src;
   int          m_ptr, n_ptr;
   bit [N-1:0]  m_mask, n_mask;
   bit [N-1:0]  exp_clear;

   // ALU behaviour controls
   bit auto_en, lag_on, allow_x0;
   int gap_lo, gap_hi, p_new;
   int hold [N];
   int idle [N];
   int rr_exp [5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   always_comb begin
      alu_res = '0;
      alu_rd  = '0;
      for (int i = 0; i < N; i++) begin
         alu_res[i*XL +: XL] = res[i];
         alu_rd[i*RW +: RW]  = rd[i];
      end
   end

   commit_arbiter #(.N_ALU(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (v),
      .alu_res   (alu_res),
      .alu_rd    (alu_rd),
      .alu_error (err),
      .alu_clear (alu_clear),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_error  (wb_error),
      .wb_src    (wb_src)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare and model next-state, evaluated while inputs are stable.
   always @(negedge clk) begin : cmp
      int g;
      int j;
      if (rst) begin
         exp_clear = '0;
         chk("rst_clear", 64'(alu_clear), 64'd0);
         chk("rst_valid", 64'(wb_valid), 64'd0);
         chk("rst_rd", 64'(wb_rd), 64'd0);
         chk("rst_data", 64'(wb_data), 64'd0);
         chk("rst_error", 64'(wb_error), 64'd0);
         chk("rst_src", 64'(wb_src), 64'd0);
      end else begin
         chk("wb_valid", 64'(wb_valid), 64'(m_valid));
         chk("wb_rd", 64'(wb_rd), 64'(m_rd));
         chk("wb_data", 64'(wb_data), 64'(m_data));
         chk("wb_error", 64'(wb_error), 64'(m_err));
         chk("wb_src", 64'(wb_src), 64'(m_src));
         g = -1;
         if (!m_valid || wb_ready) begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (g < 0 && v[j] && !m_mask[j]) g = j;
            end
         end
         exp_clear = '0;
         if (g >= 0) exp_clear[g] = 1'b1;
         chk("alu_clear", 64'(alu_clear), 64'(exp_clear));
         n_valid = m_valid;
         n_rd    = m_rd;
         n_data  = m_data;
         n_err   = m_err;
         n_src   = m_src;
         n_ptr   = m_ptr;
         n_mask  = exp_clear;
         if (g >= 0) begin
            n_ptr = (g + 1) % N;
            if (rd[g] == 0 && !err[g]) begin
               n_valid = 1'b0;
            end else begin
               n_valid = 1'b1;
               n_rd    = rd[g];
               n_data  = res[g];
               n_err   = err[g];
               n_src   = g;
            end
         end else if (m_valid && wb_ready) begin
            n_valid = 1'b0;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_rd    <= '0;
         m_data  <= '0;
         m_err   <= 1'b0;
         m_src   <= 0;
         m_ptr   <= 0;
         m_mask  <= '0;
      end else begin
         m_valid <= n_valid;
         m_rd    <= n_rd;
         m_data  <= n_data;
         m_err   <= n_err;
         m_src   <= n_src;
         m_ptr   <= n_ptr;
         m_mask  <= n_mask;
      end
   end

   task automatic new_result(input int i);
      v[i]   = 1'b1;
      res[i] = $urandom;
      rd[i]  = (allow_x0 && $urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      err[i] = ($urandom_range(0, 7) == 0);
   endtask

   // ALU lag model: after a clear, optionally keep valid one more cycle, then idle a gap.
   task automatic alu_update();
      for (int i = 0; i < N; i++) begin
         if (exp_clear[i]) begin
            if (lag_on && $urandom_range(0, 1) == 1) begin
               hold[i] = 1;
            end else begin
               v[i]    = 1'b0;
               idle[i] = $urandom_range(gap_lo, gap_hi);
            end
         end else if (hold[i] > 0) begin
            hold[i] = 0;
            v[i]    = 1'b0;
            idle[i] = $urandom_range(gap_lo, gap_hi);
         end else if (!v[i]) begin
            if (idle[i] > 0) idle[i]--;
            if (idle[i] == 0 && $urandom_range(0, 99) < p_new) new_result(i);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (auto_en) alu_update();
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      auto_en  = 1'b0;
      lag_on   = 1'b0;
      allow_x0 = 1'b0;
      gap_lo   = 1;
      gap_hi   = 1;
      p_new    = 100;
      wb_ready = 1'b0;
      v        = '1;
      err      = '0;
      for (int i = 0; i < N; i++) begin
         res[i]  = 32'h1000 + 32'(i);
         rd[i]   = 5'(i + 1);
         hold[i] = 0;
         idle[i] = 0;
      end
      #1 rst = 1'b1;

      // Reset held with all ALUs valid
      repeat (3) begin
         at_neg();
         chk("t1_clear", 64'(alu_clear), 64'd0);
         chk("t1_valid", 64'(wb_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      wb_ready = 1'b1;
      auto_en  = 1'b1;

      // Round-robin with each ALU re-asserting two cycles after its clear
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_valid", 64'(wb_valid), 64'd1);
         chk("t3_src", 64'(wb_src), 64'(rr_exp[k]));
      end

      // Single result from ALU2
      auto_en = 1'b0;
      v = '0;
      step();
      step();
      v[2] = 1'b1; rd[2] = 5'd7; res[2] = 32'hDEADBEEF; err[2] = 1'b0;
      at_neg();
      chk("t2_clear", 64'(alu_clear), 64'b0100);
      step();
      v[2] = 1'b0;
      chk("t2_valid", 64'(wb_valid), 64'd1);
      chk("t2_rd", 64'(wb_rd), 64'd7);
      chk("t2_data", 64'(wb_data), 64'hDEADBEEF);
      chk("t2_src", 64'(wb_src), 64'd2);

      // Stall with ALU1 and ALU3 pending
      wb_ready = 1'b0;
      v[1] = 1'b1; rd[1] = 5'd9;  res[1] = 32'h1111; err[1] = 1'b0;
      v[3] = 1'b1; rd[3] = 5'd10; res[3] = 32'h3333; err[3] = 1'b0;
      repeat (5) begin
         at_neg();
         chk("t4_clear", 64'(alu_clear), 64'd0);
         chk("t4_data", 64'(wb_data), 64'hDEADBEEF);
         chk("t4_valid", 64'(wb_valid), 64'd1);
         step();
      end
      wb_ready = 1'b1;
      at_neg();
      chk("t4_clear3", 64'(alu_clear), 64'b1000);
      step();
      v[3] = 1'b0;
      chk("t4_src3", 64'(wb_src), 64'd3);
      chk("t4_data3", 64'(wb_data), 64'h3333);
      at_neg();
      chk("t4_clear1", 64'(alu_clear), 64'b0010);
      step();
      v[1] = 1'b0;
      chk("t4_src1", 64'(wb_src), 64'd1);

      // Discardable x0 write, then an x0 write that carries an error
      v[0] = 1'b1; rd[0] = 5'd0; res[0] = 32'h5; err[0] = 1'b0;
      at_neg();
      chk("t5_clear", 64'(alu_clear), 64'b0001);
      step();
      v[0] = 1'b0;
      chk("t5_discard", 64'(wb_valid), 64'd0);
      step();
      v[0] = 1'b1; rd[0] = 5'd0; res[0] = 32'h0; err[0] = 1'b1;
      at_neg();
      chk("t5_clear_err", 64'(alu_clear), 64'b0001);
      step();
      v[0] = 1'b0; err[0] = 1'b0;
      chk("t5_valid", 64'(wb_valid), 64'd1);
      chk("t5_error", 64'(wb_error), 64'd1);
      chk("t5_rd", 64'(wb_rd), 64'd0);

      // ALU1 keeps valid for a cycle after its clear
      v[1] = 1'b1; rd[1] = 5'd5; res[1] = 32'h55; err[1] = 1'b0;
      at_neg();
      chk("t6_clear", 64'(alu_clear), 64'b0010);
      step();
      chk("t6_src", 64'(wb_src), 64'd1);
      at_neg();
      chk("t6_masked", 64'(alu_clear), 64'd0);
      step();
      v[1] = 1'b0;
      chk("t6_nodup", 64'(wb_valid), 64'd0);

      // Async reset pulse during a stall
      v[2] = 1'b1; rd[2] = 5'd3; res[2] = 32'h77;
      step();
      v[2] = 1'b0;
      wb_ready = 1'b0;
      chk("t6_stall_src", 64'(wb_src), 64'd2);
      v[3] = 1'b1; rd[3] = 5'd4; res[3] = 32'h88;
      step();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(wb_valid), 64'd0);
      chk("t6_rst_clear", 64'(alu_clear), 64'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      v        = '0;
      err      = '0;
      wb_ready = 1'b1;

      // Randomized traffic with ALU lag, random gaps and backpressure
      auto_en  = 1'b1;
      lag_on   = 1'b1;
      allow_x0 = 1'b1;
      gap_lo   = 0;
      gap_hi   = 3;
      p_new    = 40;
      for (int c = 0; c < 3000; c++) begin
         step();
         wb_ready = ($urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
